// File: rtl/tinyalu_pkg.sv
// Shared TinyALU types: opcodes, command-master FSM states, ALU latencies and bus widths.
package tinyalu_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned OP_W       = 3;
  localparam int unsigned RES_W      = 16;
  localparam int unsigned SINGLE_LAT = 1;
  localparam int unsigned MUL_LAT    = 4;

  typedef enum logic [OP_W-1:0] {
    NO_OP  = 3'b000,
    ADD_OP = 3'b001,
    AND_OP = 3'b010,
    XOR_OP = 3'b011,
    MUL_OP = 3'b100
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  // Opcodes that need a real ALU transaction.
  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return (op == ADD_OP) || (op == AND_OP) || (op == XOR_OP) || (op == MUL_OP);
  endfunction

endpackage

// File: rtl/tinyalu_cmd_master.sv
// Command-side master for the TinyALU: valid/ready command in, start/done ALU handshake,
// one valid/ready response per command, with a done timeout and a sticky protocol-error flag.
module tinyalu_cmd_master
  import tinyalu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [OP_W-1:0]   cmd_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic              rsp_err,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic [RES_W-1:0]  alu_result,
  output logic              proto_err
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               cmd_ready_q;
  logic               rsp_valid_q;
  logic [RES_W-1:0]   rsp_result_q;
  logic               rsp_err_q;
  logic [DATA_W-1:0]  alu_a_q;
  logic [DATA_W-1:0]  alu_b_q;
  logic [OP_W-1:0]    alu_op_q;
  logic               alu_start_q;
  logic               proto_err_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      alu_start_q  <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      if (alu_done && (state_q != ISSUE)) begin
        proto_err_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready_q <= 1'b0;
            if (is_alu_op(cmd_op)) begin
              alu_a_q     <= cmd_a;
              alu_b_q     <= cmd_b;
              alu_op_q    <= cmd_op;
              alu_start_q <= 1'b1;
              cnt_q       <= '0;
              state_q     <= ISSUE;
            end else begin
              // NOP and illegal opcodes answer locally without touching the ALU.
              rsp_result_q <= '0;
              rsp_err_q    <= (cmd_op != NO_OP);
              state_q      <= RESP;
            end
          end
        end

        ISSUE: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // A done sampled on the timeout edge still wins.
          if (alu_done) begin
            rsp_result_q <= alu_result;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            alu_start_q  <= 1'b0;
            state_q      <= RESP;
          end else if (cnt_q == TO_LAST) begin
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b1;
            rsp_valid_q  <= 1'b1;
            alu_start_q  <= 1'b0;
            state_q      <= RESP;
          end
        end

        RESP: begin
          // Locally answered commands enter RESP with the response loaded but not yet offered.
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          alu_start_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign alu_start  = alu_start_q;
  assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_tinyalu_cmd_master.sv
// Self-checking bench for tinyalu_cmd_master: TinyALU responder, transaction-level reference
// model checked every cycle, directed literal cases and randomized traffic with backpressure.
module tb_tinyalu_cmd_master;
  import tinyalu_pkg::*;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [2:0]  cmd_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_err;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        proto_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit armed = 0;

  bit never_done = 0;
  bit spurious = 0;
  bit rand_bp = 0;
  int force_lat = 0;

  logic        model_done = 1'b0;
  logic [15:0] model_res = 16'h0;
  int          alu_k = 0;

  tinyalu_cmd_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_result(input logic [7:0] a, input logic [7:0] b,
                                              input logic [2:0] op);
    case (op)
      3'd1:    return 16'(a) + 16'(b);
      3'd2:    return {8'h00, a & b};
      3'd3:    return {8'h00, a ^ b};
      3'd4:    return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  function automatic int alu_lat(input logic [2:0] op);
    if (force_lat != 0) return force_lat;
    return (op == 3'd4) ? int'(MUL_LAT) : int'(SINGLE_LAT);
  endfunction

  // TinyALU responder: done for one cycle once start has been seen for the op latency.
  always @(posedge clk) begin
    if (alu_start === 1'b1) begin
      alu_k <= alu_k + 1;
      if (!never_done && (alu_k + 1 == alu_lat(alu_op))) begin
        model_done <= 1'b1;
        model_res  <= ref_result(alu_a, alu_b, alu_op);
      end else begin
        model_done <= 1'b0;
        model_res  <= 16'($urandom);
      end
    end else begin
      alu_k      <= 0;
      model_done <= 1'b0;
      model_res  <= 16'($urandom);
    end
  end

  assign alu_done   = model_done | spurious;
  assign alu_result = model_res;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset_n === 1'b0) armed <= 1'b1;
  end

  // Reference model: one outstanding command with its accept edge, response edge and payload.
  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
    int          acc;
    int          due;
    logic [15:0] res;
    logic        err;
    bit          alu;
  } txn_t;

  txn_t q[$];
  logic exp_proto = 1'b0;

  always @(negedge clk) begin
    bit   have;
    bit   in_issue;
    bit   e_rv;
    txn_t h;
    txn_t t;
    int   lat;
    have     = (q.size() != 0);
    if (have) h = q[0];
    in_issue = have && h.alu && (cyc >= h.acc) && (cyc < h.due);
    e_rv     = have && (cyc >= h.due);
    if (armed) begin
      check("cmd_ready", 32'(cmd_ready), 32'(!have));
      check("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      check("alu_start", 32'(alu_start), 32'(in_issue));
      check("proto_err", 32'(proto_err), 32'(exp_proto));
      if (e_rv) begin
        check("rsp_result", 32'(rsp_result), 32'(h.res));
        check("rsp_err", 32'(rsp_err), 32'(h.err));
      end
      if (in_issue) begin
        check("alu_a", 32'(alu_a), 32'(h.a));
        check("alu_b", 32'(alu_b), 32'(h.b));
        check("alu_op", 32'(alu_op), 32'(h.op));
      end
    end
    if (reset_n !== 1'b1) begin
      q.delete();
      exp_proto = 1'b0;
    end else begin
      if (alu_done && !in_issue) exp_proto = 1'b1;
      if (e_rv && rsp_ready) void'(q.pop_front());
      if (!have && cmd_valid === 1'b1) begin
        t.a   = cmd_a;
        t.b   = cmd_b;
        t.op  = cmd_op;
        t.acc = cyc + 1;
        t.alu = (cmd_op >= 3'd1) && (cmd_op <= 3'd4);
        if (t.alu) begin
          lat = alu_lat(cmd_op);
          if (never_done || (lat + 1 > int'(TO))) begin
            t.due = t.acc + int'(TO);
            t.res = 16'h0;
            t.err = 1'b1;
          end else begin
            t.due = t.acc + lat + 1;
            t.res = ref_result(cmd_a, cmd_b, cmd_op);
            t.err = 1'b0;
          end
        end else begin
          t.due = t.acc + 1;
          t.res = 16'h0;
          t.err = (cmd_op != 3'd0);
        end
        q.push_back(t);
      end
    end
  end

  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    bit ok;
    ok = 0;
    @(posedge clk);
    #1;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    cmd_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) ok = 1;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept: cmd_ready stayed 0, expected 1");
    end
  endtask

  // Latency counts edges from the accept edge to the first edge that shows rsp_valid.
  task automatic get(output logic [15:0] res, output logic err, output int lat);
    bit done;
    done = 0;
    res = 16'h0;
    err = 1'b0;
    lat = -1;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1 && lat < 0) lat = i;
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        res = rsp_result;
        err = rsp_err;
        done = 1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: no response handshake, expected one");
    end
  endtask

  task automatic run_lit(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic [15:0] eres, input logic eerr,
                         input int elat);
    logic [15:0] res;
    logic        err;
    int          lat;
    send(a, b, op);
    get(res, err, lat);
    check({name, "_result"}, 32'(res), 32'(eres));
    check({name, "_err"}, 32'(err), 32'(eerr));
    check({name, "_latency"}, 32'(lat), 32'(elat));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] res;
    logic        err;
    int          lat;
    int          gap;

    reset_n   = 1'b0;
    cmd_valid = 1'b1;
    cmd_a     = 8'h5A;
    cmd_b     = 8'h3C;
    cmd_op    = 3'd1;
    spurious  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_result", 32'(rsp_result), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_alu_start", 32'(alu_start), 32'd0);
    check("rst_proto_err", 32'(proto_err), 32'd0);
    @(posedge clk);
    #1;
    spurious  = 1'b0;
    cmd_valid = 1'b0;
    reset_n   = 1'b1;

    run_lit("add_ff_01", 8'hFF, 8'h01, 3'd1, 16'h0100, 1'b0, 2);
    run_lit("mul_ff_ff", 8'hFF, 8'hFF, 3'd4, 16'hFE01, 1'b0, 5);
    run_lit("xor_aa_0f", 8'hAA, 8'h0F, 3'd3, 16'h00A5, 1'b0, 2);
    run_lit("and_f0_3c", 8'hF0, 8'h3C, 3'd2, 16'h0030, 1'b0, 2);
    run_lit("nop", 8'h12, 8'h34, 3'd0, 16'h0000, 1'b0, 1);
    run_lit("illegal_110", 8'h12, 8'h34, 3'd6, 16'h0000, 1'b1, 1);

    never_done = 1;
    run_lit("timeout", 8'h10, 8'h20, 3'd1, 16'h0000, 1'b1, 16);
    never_done = 0;

    force_lat = int'(TO) - 1;
    run_lit("done_on_timeout_edge", 8'h01, 8'h02, 3'd1, 16'h0003, 1'b0, 16);
    force_lat = 0;

    @(posedge clk);
    #1;
    spurious = 1'b1;
    @(posedge clk);
    #1;
    spurious = 1'b0;
    @(negedge clk);
    check("proto_err_spurious", 32'(proto_err), 32'd1);

    send(8'h12, 8'h34, 3'd4);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("midreset_alu_start", 32'(alu_start), 32'd0);
    check("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midreset_proto_err", 32'(proto_err), 32'd0);

    run_lit("after_reset_mul", 8'h10, 8'h10, 3'd4, 16'h0100, 1'b0, 5);

    rand_bp = 1;
    for (int n = 0; n < 60; n++) begin
      send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
      get(res, err, lat);
      gap = $urandom_range(0, 2);
      repeat (gap) @(posedge clk);
    end
    rand_bp = 0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tinyalu_cmd_master.md
# tinyalu_cmd_master

Command-side master for the TinyALU. Accepts operations on a valid/ready command channel, drives the TinyALU operand/opcode/start pins under its start/done handshake, and captures the ALU result. It returns one response per command on a valid/ready response channel. It sits between the test/host sequencer logic and the TinyALU DUT, enforcing every protocol rule the ALU-side checker asserts.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16, cycles in ISSUE without alu_done before abort; legal range 6..255

Ports:
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at an edge
- cmd_a  in  8  operand A
- cmd_b  in  8  operand B
- cmd_op  in  3  opcode
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at an edge
- rsp_result  out  16  result
- rsp_err  out  1  1 = timeout or illegal opcode
- alu_a  out  8  to TinyALU A
- alu_b  out  8  to TinyALU B
- alu_op  out  3  to TinyALU op
- alu_start  out  1  to TinyALU start
- alu_done  in  1  from TinyALU done
- alu_result  in  16  from TinyALU result
- proto_err  out  1  sticky; alu_done seen outside ISSUE

## Operation
- Opcodes: 000 NOP, 001 ADD, 010 AND, 011 XOR, 100 MUL; 101–111 illegal.
- FSM states:
  - IDLE: cmd_ready=1.
  - ISSUE: alu_start=1; alu_a, alu_b and alu_op are held from registers and stay stable for the whole state.
  - RESP: rsp_valid=1 and alu_start=0.
- Transitions:
  - IDLE to ISSUE: accept of an ALU opcode (001–100). Register the operands and opcode, and clear the timeout counter.
  - IDLE to RESP on NOP: no ALU transaction; response result 0, err 0.
  - IDLE to RESP on an illegal opcode: no ALU transaction; response result 0, err 1.
  - ISSUE to RESP when alu_done=1 is sampled: capture alu_result, err 0.
  - ISSUE to RESP when the counter reaches TIMEOUT_CYCLES-1 and alu_done=0: response result 0, err 1.
  - RESP to IDLE on rsp_ready.
- The timeout counter is 8-bit and increments every cycle in ISSUE.
- Result is passed through unmodified at 16 bits. MUL gives the full 16-bit product. ADD gives the 9-bit sum zero-extended. AND/XOR give 8 bits zero-extended. The master does no arithmetic.
- proto_err sets when alu_done=1 in IDLE or RESP. It clears only on reset.

## Timing
- Reset (reset_n=0 at an edge), on the next edge:
  - state goes to IDLE;
  - cmd_ready=1;
  - rsp_valid, rsp_result, rsp_err, alu_a, alu_b, alu_op, alu_start and proto_err all go to 0.
- Reset mid-ISSUE drops alu_start on the following edge. The in-flight command is discarded and no response is produced.
- Command accepted at edge E0:
  - alu_start=1 from E0 through the edge where alu_done is sampled.
  - ADD/AND/XOR: ALU done at cycle after E1, rsp_valid from E2, alu_start=0 from E2.
  - MUL: done 4 cycles after start rises, rsp_valid from E5.
  - NOP/illegal: rsp_valid from E1; alu_start is never raised.
- Between transactions alu_start is low for at least one cycle (the RESP cycle). The next command is accepted in IDLE, at the earliest one edge after the response handshake.
- rsp_* outputs stay stable while rsp_valid=1 && rsp_ready=0.
- If alu_done=1 on the same edge the timeout fires, done wins: result captured, err 0.
- When cmd_valid and rsp_ready are both high in RESP, only the response completes. The command waits for IDLE.

## Structure
- Shared package tinyalu_pkg holds:
  - opcode enum: NO_OP, ADD_OP, AND_OP, XOR_OP, MUL_OP;
  - state enum: IDLE, ISSUE, RESP;
  - latency constants: SINGLE_LAT=1, MUL_LAT=4.
- Single module; no sub-module is natural. The timeout counter and response register are inline.

## Test plan
- Reset with cmd_valid=1 and alu_done=1 -> after the edge, all outputs 0 and cmd_ready=1; proto_err stays 0 because reset has priority.
- ADD A=8'hFF, B=8'h01 -> start high for 2 cycles, then rsp_result=16'h0100, rsp_err=0, rsp_valid on E2.
- MUL A=8'hFF, B=8'hFF -> alu_a/b/op stable for 4 cycles, then rsp_result=16'hFE01 on E5, with start low on that cycle.
- Back-to-back XOR 8'hAA^8'h0F then AND 8'hF0&8'h3C with rsp_ready tied high -> results 16'h00A5 and 16'h0030; at least one start-low cycle between the two.
- NOP, then op=3'b110 -> no alu_start pulse; responses (0, err 0) and (0, err 1) on E1.
- ALU model that never asserts done with TIMEOUT_CYCLES=16 -> rsp_err=1, rsp_result=0 after 16 ISSUE cycles. A later spurious alu_done in IDLE sets proto_err=1.
